// File: rtl/mprj_io_serial_loader.sv
// Serial configuration loader for the mprj GPIO control-block chain.
// Fetches each pad's control word, shifts it MSB-first down the chain,
// then pulses serial_load so every pad picks up its new settings together.
module mprj_io_serial_loader #(
  parameter int unsigned IO_PADS      = 38,
  parameter int unsigned IO_CTRL_BITS = 13,
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned IDX_W        = 6
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    xfer_start,
  output logic [IDX_W-1:0]        cfg_index,
  input  logic [IO_CTRL_BITS-1:0] cfg_data,
  output logic                    busy,
  output logic                    done,
  output logic                    serial_resetn,
  output logic                    serial_clock,
  output logic                    serial_load,
  output logic                    serial_data_out
);

  localparam int unsigned BIT_W = (IO_CTRL_BITS > 1) ? $clog2(IO_CTRL_BITS) : 1;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SH_LO = 3'd2;
  localparam logic [2:0] S_SH_HI = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [IDX_W-1:0] PAD_LAST = IDX_W'(IO_PADS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(IO_CTRL_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [2:0]              state, state_n;
  logic [IDX_W-1:0]        pad, pad_n;
  logic [BIT_W-1:0]        bit_cnt, bit_n;
  logic [DIV_W-1:0]        div_cnt, div_n;
  logic [IO_CTRL_BITS-1:0] shreg, shreg_n;
  logic                    pending, pending_n;

  logic [IDX_W-1:0]        cfg_index_n;
  logic                    busy_n, done_n, sclk_n, sload_n, sdata_n;

  // Next-state, counter and output decode; outputs follow the next state so they register cleanly
  always_comb begin
    state_n   = state;
    pad_n     = pad;
    bit_n     = bit_cnt;
    div_n     = div_cnt;
    shreg_n   = shreg;
    pending_n = pending;

    if (state != S_IDLE && xfer_start) pending_n = 1'b1;

    case (state)
      S_IDLE: begin
        if (xfer_start) begin
          state_n = S_LOAD;
          pad_n   = PAD_LAST;
        end
      end
      S_LOAD: begin
        shreg_n = cfg_data;
        bit_n   = BIT_LAST;
        div_n   = '0;
        state_n = S_SH_LO;
      end
      S_SH_LO: begin
        if (div_cnt == DIV_LAST) begin
          div_n   = '0;
          state_n = S_SH_HI;
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      S_SH_HI: begin
        if (div_cnt == DIV_LAST) begin
          div_n   = '0;
          shreg_n = shreg << 1;
          if (bit_cnt != '0) begin
            bit_n   = bit_cnt - BIT_W'(1);
            state_n = S_SH_LO;
          end else if (pad != '0) begin
            pad_n   = pad - IDX_W'(1);
            state_n = S_LOAD;
          end else begin
            state_n = S_LATCH;
          end
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      S_LATCH: begin
        if (div_cnt == DIV_LAST) begin
          div_n   = '0;
          state_n = S_DONE;
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      S_DONE: begin
        // A request seen during the run (or in this very cycle) triggers exactly one re-run
        pending_n = 1'b0;
        if (pending || xfer_start) begin
          state_n = S_LOAD;
          pad_n   = PAD_LAST;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    busy_n      = (state_n != S_IDLE);
    done_n      = (state_n == S_DONE);
    sclk_n      = (state_n == S_SH_HI);
    sload_n     = (state_n == S_LATCH);
    sdata_n     = (state_n == S_SH_LO || state_n == S_SH_HI) ? shreg_n[IO_CTRL_BITS-1] : 1'b0;
    cfg_index_n = (state_n == S_LOAD) ? pad_n : '0;
  end

  // State, datapath and registered outputs; reset also drives the chain reset low
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state           <= S_IDLE;
      pad             <= '0;
      bit_cnt         <= '0;
      div_cnt         <= '0;
      shreg           <= '0;
      pending         <= 1'b0;
      cfg_index       <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      serial_resetn   <= 1'b0;
      serial_clock    <= 1'b0;
      serial_load     <= 1'b0;
      serial_data_out <= 1'b0;
    end else begin
      state           <= state_n;
      pad             <= pad_n;
      bit_cnt         <= bit_n;
      div_cnt         <= div_n;
      shreg           <= shreg_n;
      pending         <= pending_n;
      cfg_index       <= cfg_index_n;
      busy            <= busy_n;
      done            <= done_n;
      serial_resetn   <= 1'b1;
      serial_clock    <= sclk_n;
      serial_load     <= sload_n;
      serial_data_out <= sdata_n;
    end
  end

endmodule
